// File: rtl/simple_processor_pkg.sv
// Shared types for the simple processor: operation codes, instruction field
// positions, the decoded-instruction bundle and the decode-stage skid states.
package simple_processor_pkg;

  localparam int FUNC_LSB = 0;
  localparam int RD_LSB   = 5;
  localparam int RS1_LSB  = 10;
  localparam int RS2_LSB  = 15;
  localparam int IMM_LSB  = 20;
  localparam int RSVD_LSB = 26;

  localparam int FUNC_W = 5;
  localparam int REG_W  = 5;
  localparam int IMM_W  = 6;

  typedef enum logic [4:0] {
    ADD     = 5'd0,
    ADDI    = 5'd1,
    SUB     = 5'd2,
    AND     = 5'd3,
    OR      = 5'd4,
    XOR     = 5'd5,
    NOT     = 5'd6,
    SLL     = 5'd7,
    SLLI    = 5'd8,
    SLR     = 5'd9,
    SLRI    = 5'd10,
    LOAD    = 5'd11,
    STORE   = 5'd12,
    INVALID = 5'd31
  } func_t;

  typedef struct packed {
    func_t            func;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [IMM_W-1:0] imm;
    logic             we;
    logic             illegal;
  } dec_instr_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } skid_state_t;

  localparam dec_instr_t DEC_RESET = '{
    func: ADD, rd: 5'd0, rs1: 5'd0, rs2: 5'd0, imm: 6'd0, we: 1'b0, illegal: 1'b0
  };

  // Forms that carry an immediate instead of a second source register.
  function automatic logic is_imm_form(input func_t f);
    logic r;
    case (f)
      ADDI, SLLI, SLRI, LOAD, STORE: r = 1'b1;
      default:                       r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_decode_stage_decoder.sv
// Combinational instruction decoder: raw instruction word -> dec_instr_t.
// Illegal words collapse to an all-zero INVALID bundle with illegal set.
module instr_decoder
  import simple_processor_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] instr,
  output dec_instr_t            dec
);

  logic [FUNC_W-1:0] code;
  logic              rsvd_set;

  assign code     = instr[FUNC_LSB +: FUNC_W];
  assign rsvd_set = |instr[DATA_WIDTH-1:RSVD_LSB];

  always_comb begin
    dec = '{func: INVALID, rd: 5'd0, rs1: 5'd0, rs2: 5'd0, imm: 6'd0,
            we: 1'b0, illegal: 1'b1};
    if (!rsvd_set && (code <= 5'd12)) begin
      dec.func    = func_t'(code);
      dec.rd      = instr[RD_LSB  +: REG_W];
      dec.rs1     = instr[RS1_LSB +: REG_W];
      dec.rs2     = instr[RS2_LSB +: REG_W];
      dec.imm     = instr[IMM_LSB +: IMM_W];
      dec.we      = (func_t'(code) != STORE);
      dec.illegal = 1'b0;
      if (is_imm_form(func_t'(code))) begin
        dec.rs2 = 5'd0;
      end else begin
        dec.imm = 6'd0;
      end
      // NOT has a single source operand.
      if (func_t'(code) == NOT) begin
        dec.rs2 = 5'd0;
      end else begin
        dec.rs2 = dec.rs2;
      end
    end else begin
      dec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage: decodes fetch words and presents them to execute from a
// registered output backed by a 2-entry skid buffer. Optional statistics
// counters are enabled with the DECODE_STATS_EN macro.
module instr_decode_stage
  import simple_processor_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] instr_i,
  input  logic                  instr_valid_i,
  output logic                  instr_ready_o,
  output logic                  dec_valid_o,
  input  logic                  dec_ready_i,
  output func_t                 func_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic [REG_ADDR_W-1:0] rs1_addr_o,
  output logic [REG_ADDR_W-1:0] rs2_addr_o,
  output logic [5:0]            imm_o,
  output logic                  we_o,
  output logic                  illegal_o
`ifdef DECODE_STATS_EN
  , output logic [CNT_W-1:0]    dec_count_o,
  output logic [CNT_W-1:0]      illegal_count_o
`endif
);

  skid_state_t state_r, next_state;
  dec_instr_t  dec, out_r, skid_r;
  logic        dec_valid_r, instr_ready_r;
  logic        in_xfer, out_xfer;
  logic        load_out, load_skid, skid_to_out;

  instr_decoder #(.DATA_WIDTH(DATA_WIDTH)) u_decoder (
    .instr (instr_i),
    .dec   (dec)
  );

  assign in_xfer  = instr_valid_i & instr_ready_r;
  assign out_xfer = dec_valid_r & dec_ready_i;

  always_comb begin
    next_state  = state_r;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    if (flush_i) begin
      next_state = S_EMPTY;
    end else begin
      case (state_r)
        S_EMPTY: begin
          if (in_xfer) begin
            load_out   = 1'b1;
            next_state = S_ONE;
          end else begin
            next_state = S_EMPTY;
          end
        end
        S_ONE: begin
          if (in_xfer && out_xfer) begin
            load_out   = 1'b1;
            next_state = S_ONE;
          end else if (in_xfer) begin
            load_skid  = 1'b1;
            next_state = S_TWO;
          end else if (out_xfer) begin
            next_state = S_EMPTY;
          end else begin
            next_state = S_ONE;
          end
        end
        S_TWO: begin
          if (out_xfer) begin
            skid_to_out = 1'b1;
            next_state  = S_ONE;
          end else begin
            next_state = S_TWO;
          end
        end
        default: next_state = S_EMPTY;
      endcase
    end
  end

  // Valid and ready are registered copies of the next state.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_r       <= S_EMPTY;
      dec_valid_r   <= 1'b0;
      instr_ready_r <= 1'b1;
    end else begin
      state_r       <= next_state;
      dec_valid_r   <= (next_state != S_EMPTY);
      instr_ready_r <= (next_state != S_TWO);
    end
  end

  // Output register and skid entry.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      out_r  <= DEC_RESET;
      skid_r <= DEC_RESET;
    end else begin
      if (load_out) begin
        out_r <= dec;
      end else if (skid_to_out) begin
        out_r <= skid_r;
      end
      if (load_skid) begin
        skid_r <= dec;
      end
    end
  end

`ifdef DECODE_STATS_EN
  logic [CNT_W-1:0] dec_count_r, illegal_count_r;

  // Saturating counters; flush does not clear them.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      dec_count_r     <= {CNT_W{1'b0}};
      illegal_count_r <= {CNT_W{1'b0}};
    end else begin
      if (out_xfer && (dec_count_r != {CNT_W{1'b1}})) begin
        dec_count_r <= dec_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (out_xfer && out_r.illegal && (illegal_count_r != {CNT_W{1'b1}})) begin
        illegal_count_r <= illegal_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign dec_count_o     = dec_count_r;
  assign illegal_count_o = illegal_count_r;
`endif

  assign instr_ready_o = instr_ready_r;
  assign dec_valid_o   = dec_valid_r;
  assign func_o        = out_r.func;
  assign rd_addr_o     = out_r.rd;
  assign rs1_addr_o    = out_r.rs1;
  assign rs2_addr_o    = out_r.rs2;
  assign imm_o         = out_r.imm;
  assign we_o          = out_r.we;
  assign illegal_o     = out_r.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: decode vector table plus
// hand-written backpressure, flush, reset and (optional) statistics sequences.
module tb_instr_decode_stage;
  import simple_processor_pkg::*;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic        dec_valid;
  logic        dec_ready = 1'b1;
  func_t       func;
  logic [4:0]  rd, rs1, rs2;
  logic [5:0]  imm;
  logic        we, illegal;
`ifdef DECODE_STATS_EN
  logic [3:0]  dec_count, illegal_count;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  instr_decode_stage #(.DATA_WIDTH(32), .REG_ADDR_W(5), .CNT_W(4)) dut (
    .clk_i         (clk),
    .arst_i        (arst),
    .flush_i       (flush),
    .instr_i       (instr),
    .instr_valid_i (instr_valid),
    .instr_ready_o (instr_ready),
    .dec_valid_o   (dec_valid),
    .dec_ready_i   (dec_ready),
    .func_o        (func),
    .rd_addr_o     (rd),
    .rs1_addr_o    (rs1),
    .rs2_addr_o    (rs2),
    .imm_o         (imm),
    .we_o          (we),
    .illegal_o     (illegal)
`ifdef DECODE_STATS_EN
    , .dec_count_o     (dec_count),
    .illegal_count_o (illegal_count)
`endif
  );

  typedef struct {
    logic [31:0] instr;
    func_t       func;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [5:0]  imm;
    logic        we;
    logic        ill;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [31:0] enc(input logic [5:0] rsvd, input logic [5:0] im,
                                      input logic [4:0] r2, input logic [4:0] r1,
                                      input logic [4:0] d, input logic [4:0] fn);
    return {rsvd, im, r2, r1, d, fn};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic check_fields(input string tag, input func_t f, input logic [4:0] d,
                              input logic [4:0] r1, input logic [4:0] r2,
                              input logic [5:0] im, input logic w, input logic il);
    check({tag, ".valid"}, {31'd0, dec_valid}, 32'd1);
    check({tag, ".func"}, {27'd0, func}, {27'd0, f});
    check({tag, ".rd"}, {27'd0, rd}, {27'd0, d});
    check({tag, ".rs1"}, {27'd0, rs1}, {27'd0, r1});
    check({tag, ".rs2"}, {27'd0, rs2}, {27'd0, r2});
    check({tag, ".imm"}, {26'd0, imm}, {26'd0, im});
    check({tag, ".we"}, {31'd0, we}, {31'd0, w});
    check({tag, ".illegal"}, {31'd0, illegal}, {31'd0, il});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".valid"}, {31'd0, dec_valid}, 32'd0);
    check({tag, ".ready"}, {31'd0, instr_ready}, 32'd1);
    check({tag, ".func"}, {27'd0, func}, {27'd0, ADD});
    check({tag, ".rd"}, {27'd0, rd}, 32'd0);
    check({tag, ".rs1"}, {27'd0, rs1}, 32'd0);
    check({tag, ".rs2"}, {27'd0, rs2}, 32'd0);
    check({tag, ".imm"}, {26'd0, imm}, 32'd0);
    check({tag, ".we"}, {31'd0, we}, 32'd0);
    check({tag, ".illegal"}, {31'd0, illegal}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{32'h03F00461, ADDI, 5'd3, 5'd1, 5'd0, 6'h3F, 1'b1, 1'b0};
    vecs[1]  = '{32'h0000000D, INVALID, 5'd0, 5'd0, 5'd0, 6'h00, 1'b0, 1'b1};
    vecs[2]  = '{32'h80000000, INVALID, 5'd0, 5'd0, 5'd0, 6'h00, 1'b0, 1'b1};
    vecs[3]  = '{enc(6'd0, 6'h15, 5'd9, 5'd8, 5'd7, 5'd0), ADD, 5'd7, 5'd8, 5'd9, 6'h00, 1'b1, 1'b0};
    vecs[4]  = '{enc(6'd0, 6'h05, 5'd31, 5'd4, 5'd2, 5'd6), NOT, 5'd2, 5'd4, 5'd0, 6'h00, 1'b1, 1'b0};
    vecs[5]  = '{enc(6'd0, 6'h2A, 5'd3, 5'd2, 5'd1, 5'd12), STORE, 5'd1, 5'd2, 5'd0, 6'h2A, 1'b0, 1'b0};
    vecs[6]  = '{enc(6'd0, 6'h01, 5'd5, 5'd30, 5'd31, 5'd11), LOAD, 5'd31, 5'd30, 5'd0, 6'h01, 1'b1, 1'b0};
    vecs[7]  = '{enc(6'd0, 6'h3F, 5'd7, 5'd6, 5'd5, 5'd9), SLR, 5'd5, 5'd6, 5'd7, 6'h00, 1'b1, 1'b0};
    vecs[8]  = '{enc(6'd0, 6'h03, 5'd3, 5'd3, 5'd3, 5'd31), INVALID, 5'd0, 5'd0, 5'd0, 6'h00, 1'b0, 1'b1};
    vecs[9]  = '{enc(6'd1, 6'h00, 5'd1, 5'd2, 5'd3, 5'd5), INVALID, 5'd0, 5'd0, 5'd0, 6'h00, 1'b0, 1'b1};
    vecs[10] = '{enc(6'd0, 6'h20, 5'd10, 5'd0, 5'd0, 5'd10), SLRI, 5'd0, 5'd0, 5'd0, 6'h20, 1'b1, 1'b0};
    vecs[11] = '{enc(6'd0, 6'h1F, 5'd1, 5'd2, 5'd3, 5'd8), SLLI, 5'd3, 5'd2, 5'd0, 6'h1F, 1'b1, 1'b0};
    vecs[12] = '{enc(6'd0, 6'h01, 5'd1, 5'd1, 5'd1, 5'd13), INVALID, 5'd0, 5'd0, 5'd0, 6'h00, 1'b0, 1'b1};

    // Reset state while reset is held.
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    arst = 1'b0;
    @(negedge clk);

`ifdef DECODE_STATS_EN
    // 20 legal words: counter saturates at 15, illegal counter stays 0.
    dec_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      instr = enc(6'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0);
      instr_valid = 1'b1;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("stats.dec_count", {28'd0, dec_count}, 32'd15);
    check("stats.illegal_count", {28'd0, illegal_count}, 32'd0);
`endif

    // Decode table, streamed back to back with execute always ready.
    dec_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      instr = vecs[i].instr;
      instr_valid = 1'b1;
      @(negedge clk);
      check_fields($sformatf("vec%0d", i), vecs[i].func, vecs[i].rd, vecs[i].rs1,
                   vecs[i].rs2, vecs[i].imm, vecs[i].we, vecs[i].ill);
    end
    instr_valid = 1'b0;
    @(negedge clk);
    check("drain.valid", {31'd0, dec_valid}, 32'd0);

    // Backpressure: ADD held, SUB in skid, OR refused until release.
    dec_ready = 1'b0;
    instr = enc(6'd0, 6'd0, 5'd0, 5'd0, 5'd1, 5'd0);
    instr_valid = 1'b1;
    @(negedge clk);
    check("bp.add_func", {27'd0, func}, {27'd0, ADD});
    check("bp.ready_one", {31'd0, instr_ready}, 32'd1);
    instr = enc(6'd0, 6'd0, 5'd0, 5'd0, 5'd2, 5'd2);
    @(negedge clk);
    check("bp.ready_two", {31'd0, instr_ready}, 32'd0);
    check("bp.hold_rd", {27'd0, rd}, 32'd1);
    instr = enc(6'd0, 6'd0, 5'd0, 5'd0, 5'd3, 5'd4);
    @(negedge clk);
    check("bp.still_full", {31'd0, instr_ready}, 32'd0);
    check("bp.hold_func", {27'd0, func}, {27'd0, ADD});
    check("bp.hold_valid", {31'd0, dec_valid}, 32'd1);
    dec_ready = 1'b1;
    @(negedge clk);
    check("bp.sub_func", {27'd0, func}, {27'd0, SUB});
    check("bp.sub_rd", {27'd0, rd}, 32'd2);
    @(negedge clk);
    instr_valid = 1'b0;
    check("bp.or_func", {27'd0, func}, {27'd0, OR});
    check("bp.or_rd", {27'd0, rd}, 32'd3);
    @(negedge clk);
    check("bp.empty", {31'd0, dec_valid}, 32'd0);

    // Flush in TWO with a STORE offered at the same time.
    dec_ready = 1'b0;
    instr = enc(6'd0, 6'd0, 5'd0, 5'd0, 5'd4, 5'd0);
    instr_valid = 1'b1;
    @(negedge clk);
    instr = enc(6'd0, 6'd0, 5'd0, 5'd0, 5'd5, 5'd2);
    @(negedge clk);
    check("fl.two_ready", {31'd0, instr_ready}, 32'd0);
    flush = 1'b1;
    instr = enc(6'd0, 6'h11, 5'd0, 5'd1, 5'd2, 5'd12);
    @(negedge clk);
    check("fl.valid", {31'd0, dec_valid}, 32'd0);
    check("fl.ready", {31'd0, instr_ready}, 32'd1);
    flush = 1'b0;
    instr_valid = 1'b0;
    dec_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("fl.no_store%0d", i), {31'd0, dec_valid}, 32'd0);
    end

    // Asynchronous reset in TWO.
    dec_ready = 1'b0;
    instr = enc(6'd0, 6'd0, 5'd0, 5'd1, 5'd6, 5'd5);
    instr_valid = 1'b1;
    @(negedge clk);
    instr = enc(6'd0, 6'd0, 5'd0, 5'd1, 5'd7, 5'd2);
    @(negedge clk);
    check("rst.pre_func", {27'd0, func}, {27'd0, XOR});
    instr_valid = 1'b0;
    #1 arst = 1'b1;
    #1 check_reset_outputs("rst.async");
    @(negedge clk);
    arst = 1'b0;
    dec_ready = 1'b1;
    instr = enc(6'd0, 6'd0, 5'd0, 5'd2, 5'd9, 5'd3);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    check_fields("rst.first", AND, 5'd9, 5'd2, 5'd0, 6'd0, 1'b1, 1'b0);
    @(negedge clk);
    check("rst.drain", {31'd0, dec_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
